// File: rtl/hash_cmp.sv
// SHA-256 / SHA-384 compression core: one round per clock, then a feed-forward add into the chaining value.
// Schedule words and round constants come from outside, addressed by rnd_idx.
module hash_cmp (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         h_flg_384,
    input  logic         h_clr,
    input  logic         cmp_start,
    input  logic [63:0]  w,
    input  logic [63:0]  kt,
    output logic [6:0]   rnd_idx,
    output logic         kw_nxt,
    output logic         kw_done,
    output logic         cmp_busy,
    output logic         cmp_done,
    output logic [511:0] hash_f
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        ADD   = 2'd2
    } state_t;

    localparam logic [63:0] IV256 [8] = '{
        64'h6a09e667, 64'hbb67ae85, 64'h3c6ef372, 64'ha54ff53a,
        64'h510e527f, 64'h9b05688c, 64'h1f83d9ab, 64'h5be0cd19
    };
    localparam logic [63:0] IV384 [8] = '{
        64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
        64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4
    };

    state_t      state_q, state_d;
    logic        mode_q, mode_d;
    logic [63:0] h_q [8];
    logic [63:0] h_d [8];
    logic [63:0] wk_q [8];
    logic [63:0] wk_d [8];
    logic [63:0] rnd_wk [8];
    logic [6:0]  rnd_q, rnd_d;

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [31:0] rotr32(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // SHA-256 values live in the low half with the upper half forced to zero.
    function automatic logic [63:0] msk(input logic [63:0] x, input logic m);
        return m ? x : {32'd0, x[31:0]};
    endfunction

    function automatic logic [63:0] big_sig0(input logic [63:0] x, input logic m);
        if (m)
            return rotr64(x, 28) ^ rotr64(x, 34) ^ rotr64(x, 39);
        return {32'd0, rotr32(x[31:0], 2) ^ rotr32(x[31:0], 13) ^ rotr32(x[31:0], 22)};
    endfunction

    function automatic logic [63:0] big_sig1(input logic [63:0] x, input logic m);
        if (m)
            return rotr64(x, 14) ^ rotr64(x, 18) ^ rotr64(x, 41);
        return {32'd0, rotr32(x[31:0], 6) ^ rotr32(x[31:0], 11) ^ rotr32(x[31:0], 25)};
    endfunction

    logic [63:0] w_sel, k_sel, s0, s1, ch, maj, t1, t2;

    always_comb begin
        w_sel = mode_q ? w  : {32'd0, w[63:32]};
        k_sel = mode_q ? kt : {32'd0, kt[63:32]};
        s0    = big_sig0(wk_q[0], mode_q);
        s1    = big_sig1(wk_q[4], mode_q);
        ch    = (wk_q[4] & wk_q[5]) ^ (~wk_q[4] & wk_q[6]);
        maj   = (wk_q[0] & wk_q[1]) ^ (wk_q[0] & wk_q[2]) ^ (wk_q[1] & wk_q[2]);
        t1    = msk(wk_q[7] + s1 + ch + k_sel + w_sel, mode_q);
        t2    = msk(s0 + maj, mode_q);
        rnd_wk[0] = msk(t1 + t2, mode_q);
        rnd_wk[1] = wk_q[0];
        rnd_wk[2] = wk_q[1];
        rnd_wk[3] = wk_q[2];
        rnd_wk[4] = msk(wk_q[3] + t1, mode_q);
        rnd_wk[5] = wk_q[4];
        rnd_wk[6] = wk_q[5];
        rnd_wk[7] = wk_q[6];
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        h_d      = h_q;
        wk_d     = wk_q;
        rnd_d    = rnd_q;
        kw_nxt   = 1'b0;
        kw_done  = 1'b0;
        cmp_done = 1'b0;
        if (h_clr) begin
            state_d = IDLE;
            mode_d  = h_flg_384;
            rnd_d   = 7'd0;
            for (int i = 0; i < 8; i++)
                h_d[i] = h_flg_384 ? IV384[i] : IV256[i];
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmp_start) begin
                        wk_d    = h_q;
                        rnd_d   = 7'd0;
                        state_d = ROUND;
                    end
                end
                ROUND: begin
                    kw_nxt = 1'b1;
                    wk_d   = rnd_wk;
                    rnd_d  = rnd_q + 7'd1;
                    if (rnd_q == (mode_q ? 7'd79 : 7'd63))
                        state_d = ADD;
                end
                ADD: begin
                    kw_done  = 1'b1;
                    cmp_done = 1'b1;
                    for (int i = 0; i < 8; i++)
                        h_d[i] = msk(h_q[i] + wk_q[i], mode_q);
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            rnd_q   <= 7'd0;
            for (int i = 0; i < 8; i++) begin
                h_q[i]  <= '0;
                wk_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            rnd_q   <= rnd_d;
            for (int i = 0; i < 8; i++) begin
                h_q[i]  <= h_d[i];
                wk_q[i] <= wk_d[i];
            end
        end
    end

    assign rnd_idx  = rnd_q;
    assign cmp_busy = (state_q != IDLE);

    always_comb begin
        if (mode_q)
            hash_f = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4], h_q[5], 128'd0};
        else
            hash_f = {h_q[0][31:0], h_q[1][31:0], h_q[2][31:0], h_q[3][31:0],
                      h_q[4][31:0], h_q[5][31:0], h_q[6][31:0], h_q[7][31:0], 256'd0};
    end

endmodule

// File: tb/tb_hash_cmp.sv
// Bench for hash_cmp: acts as message-schedule stage and constant ROM, checks digests against known FIPS vectors.
module tb_hash_cmp;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         h_flg_384 = 1'b0;
    logic         h_clr = 1'b0;
    logic         cmp_start = 1'b0;
    logic [63:0]  w, kt;
    logic [6:0]   rnd_idx;
    logic         kw_nxt, kw_done, cmp_busy, cmp_done;
    logic [511:0] hash_f;

    int nchk = 0;
    int nfail = 0;

    logic [63:0] sched [80];
    logic [63:0] msg [16];

    // SHA-512 round constants; the top 32 bits of the first 64 are the SHA-256 constants.
    localparam logic [63:0] K [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    localparam logic [511:0] IVF256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                       32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19, 256'd0};
    localparam logic [511:0] IVF384 = {64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17,
                                       64'h152fecd8f70e5939, 64'h67332667ffc00b31, 64'h8eb44a8768581511, 128'd0};
    localparam logic [511:0] ABC256 = {256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, 256'd0};
    localparam logic [511:0] ABC384 = {384'hcb00753f45a35e8bb5a03d699ac65007272c32ab0eded1631a8b605a43ff5bed8086072ba1e7cc2358baeca134c825a7, 128'd0};
    localparam logic [511:0] TWO256 = {256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1, 256'd0};

    hash_cmp dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .h_flg_384 (h_flg_384),
        .h_clr     (h_clr),
        .cmp_start (cmp_start),
        .w         (w),
        .kt        (kt),
        .rnd_idx   (rnd_idx),
        .kw_nxt    (kw_nxt),
        .kw_done   (kw_done),
        .cmp_busy  (cmp_busy),
        .cmp_done  (cmp_done),
        .hash_f    (hash_f)
    );

    always #5 clk = ~clk;

    always_comb begin
        w  = '0;
        kt = '0;
        if (rnd_idx < 7'd80) begin
            w  = sched[rnd_idx];
            kt = K[rnd_idx];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] expv);
        nchk++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    function automatic logic [31:0] r32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [63:0] r64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    task automatic load_blk(input int id);
        for (int i = 0; i < 16; i++) msg[i] = '0;
        case (id)
            0: begin msg[0] = 64'h61626380; msg[15] = 64'h18; end
            1: begin msg[0] = 64'h6162638000000000; msg[15] = 64'h18; end
            2: begin
                msg[0]  = 64'h61626364; msg[1]  = 64'h62636465; msg[2]  = 64'h63646566;
                msg[3]  = 64'h64656667; msg[4]  = 64'h65666768; msg[5]  = 64'h66676869;
                msg[6]  = 64'h6768696a; msg[7]  = 64'h68696a6b; msg[8]  = 64'h696a6b6c;
                msg[9]  = 64'h6a6b6c6d; msg[10] = 64'h6b6c6d6e; msg[11] = 64'h6c6d6e6f;
                msg[12] = 64'h6d6e6f70; msg[13] = 64'h6e6f7071; msg[14] = 64'h80000000;
            end
            default: msg[15] = 64'h1c0;
        endcase
    endtask

    // SHA-256 words are presented on w[63:32].
    task automatic build_sched(input logic m384);
        logic [31:0] y2, y15, res;
        logic [63:0] x2, x15;
        for (int t = 0; t < 16; t++)
            sched[t] = m384 ? msg[t] : {msg[t][31:0], 32'd0};
        for (int t = 16; t < 80; t++) begin
            if (m384) begin
                x2  = sched[t-2];
                x15 = sched[t-15];
                sched[t] = (r64(x2, 19) ^ r64(x2, 61) ^ (x2 >> 6)) + sched[t-7]
                         + (r64(x15, 1) ^ r64(x15, 8) ^ (x15 >> 7)) + sched[t-16];
            end else begin
                y2  = sched[t-2][63:32];
                y15 = sched[t-15][63:32];
                res = (r32(y2, 17) ^ r32(y2, 19) ^ (y2 >> 10)) + sched[t-7][63:32]
                    + (r32(y15, 7) ^ r32(y15, 18) ^ (y15 >> 3)) + sched[t-16][63:32];
                sched[t] = {res, 32'd0};
            end
        end
    endtask

    // Called and returns on a falling edge.
    task automatic do_clr(input logic m384);
        h_flg_384 = m384;
        h_clr = 1'b1;
        @(negedge clk);
        h_clr = 1'b0;
    endtask

    // Cycle T is the one in which cmp_start is high; returns at mid-cycle of T+done+1.
    task automatic run_block(input string nm, input logic m384, input int poke,
                             input logic chk_hash, input logic [511:0] expv);
        int k, done_at, nkw, bad_rnd, last;
        logic poked, kwd, bsy;
        last = m384 ? 81 : 65;
        cmp_start = 1'b1;
        @(negedge clk);
        k = 1; done_at = 0; nkw = 0; bad_rnd = 0; poked = 1'b0; kwd = 1'b0; bsy = 1'b0;
        while (done_at == 0 && k < 200) begin
            cmp_start = 1'b0;
            if (kw_nxt) begin
                nkw++;
                if (rnd_idx != 7'(k - 1)) bad_rnd++;
            end
            if (cmp_done) begin
                done_at = k;
                kwd = kw_done;
                bsy = cmp_busy;
            end else begin
                if (poke >= 0 && !poked && kw_nxt && rnd_idx == 7'(poke)) begin
                    cmp_start = 1'b1;
                    poked = 1'b1;
                end
                @(negedge clk);
                k++;
            end
        end
        cmp_start = 1'b0;
        chk({nm, "_done_cycle"}, done_at, last);
        chk({nm, "_kw_nxt_cnt"}, nkw, last - 1);
        chk({nm, "_rnd_seq_err"}, bad_rnd, 0);
        chk({nm, "_add_strobes"}, {kwd, bsy}, 2'b11);
        @(negedge clk);
        chk({nm, "_after_add"}, {cmp_done, kw_done, kw_nxt, cmp_busy}, 4'b0);
        chk({nm, "_rnd_hold"}, rnd_idx, last - 1);
        if (chk_hash) chk({nm, "_digest"}, hash_f, expv);
    endtask

    task automatic wait_rnd(input string nm, input int r);
        int k;
        k = 0;
        while (!(kw_nxt && rnd_idx == 7'(r)) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_reach_round"}, (k < 200), 1);
    endtask

    typedef struct {
        logic         do_clr;
        logic         m384;
        logic         run;
        int           blk_id;
        logic [511:0] expv;
    } vec_t;

    initial begin
        vec_t vecs [5];
        int   cnt;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 0, IVF256};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 0, IVF384};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 0, ABC256};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1, ABC384};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 0, IVF256};

        for (int i = 0; i < 80; i++) sched[i] = '0;
        #2;
        chk("reset_ctl", {rnd_idx, kw_nxt, kw_done, cmp_busy, cmp_done}, 0);
        chk("reset_hash", hash_f, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_hash", hash_f, 0);

        for (int i = 0; i < 5; i++) begin
            if (vecs[i].do_clr) do_clr(vecs[i].m384);
            if (vecs[i].run) begin
                load_blk(vecs[i].blk_id);
                build_sched(vecs[i].m384);
                run_block($sformatf("vec%0d", i), vecs[i].m384, -1, 1'b1, vecs[i].expv);
            end else begin
                chk($sformatf("vec%0d_iv", i), hash_f, vecs[i].expv);
            end
        end

        // Two-block message, second start immediately after the first ADD.
        do_clr(1'b0);
        load_blk(2);
        build_sched(1'b0);
        run_block("two_b1", 1'b0, -1, 1'b0, '0);
        load_blk(3);
        build_sched(1'b0);
        run_block("two_b2", 1'b0, -1, 1'b1, TWO256);

        do_clr(1'b0);
        load_blk(0);
        build_sched(1'b0);
        run_block("start_r10", 1'b0, 10, 1'b1, ABC256);

        // Abort with h_clr at round 30.
        do_clr(1'b0);
        load_blk(0);
        build_sched(1'b0);
        cmp_start = 1'b1;
        @(negedge clk);
        cmp_start = 1'b0;
        wait_rnd("clr30", 30);
        h_clr = 1'b1;
        #1;
        chk("clr30_suppress", {kw_nxt, kw_done, cmp_done}, 3'b0);
        @(negedge clk);
        h_clr = 1'b0;
        chk("clr30_busy", cmp_busy, 1'b0);
        chk("clr30_h0", hash_f[511:480], 32'h6a09e667);
        chk("clr30_rnd", rnd_idx, 7'd0);
        chk("clr30_hash", hash_f, IVF256);
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (cmp_done || kw_done || kw_nxt || cmp_busy) cnt++;
        end
        chk("clr30_quiet", cnt, 0);

        // Reset in the middle of a block, then rerun.
        load_blk(0);
        build_sched(1'b0);
        cmp_start = 1'b1;
        @(negedge clk);
        cmp_start = 1'b0;
        wait_rnd("rst40", 40);
        rst_n = 1'b0;
        #1;
        chk("rst40_ctl", {rnd_idx, kw_nxt, kw_done, cmp_busy, cmp_done}, 0);
        chk("rst40_hash", hash_f, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_clr(1'b0);
        run_block("rerun", 1'b0, -1, 1'b1, ABC256);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/hash_cmp.md
HASH_CMP -- requirements
Module: hash_cmp

Interface
REQ-001 SHALL have clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-002 SHALL have rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have h_flg_384, input, 1: 1 selects the SHA-384 datapath (64-bit words, 80 rounds); 0 selects SHA-256 (32-bit words, 64 rounds). It must be held stable while cmp_busy is high.
REQ-004 SHALL have h_clr, input, 1: loads the initial hash values for the mode on h_flg_384, and aborts any running operation.
REQ-005 SHALL have cmp_start, input, 1: a single-cycle pulse that starts compression of the block held in the message-schedule stage.
REQ-006 SHALL have w, input, 64: the current schedule word W_t. In SHA-256 mode only w[63:32] is used.
REQ-007 SHALL have kt, input, 64: round constant K_t from the shared constant ROM, addressed by rnd_idx. In SHA-256 mode only kt[63:32] is used.
REQ-008 SHALL have rnd_idx, output, 7: the current round index.
REQ-009 SHALL have kw_nxt, output, 1: a schedule-advance strobe to the message-schedule stage.
REQ-010 SHALL have kw_done, output, 1: a schedule-clear strobe to the message-schedule stage.
REQ-011 SHALL have cmp_busy, output, 1: high while a compression is in progress.
REQ-012 SHALL have cmp_done, output, 1: a one-cycle pulse when the chaining value has been updated.
REQ-013 SHALL have hash_f, output, 512: the MSB-aligned digest.

Function
REQ-014 SHALL implement a state machine with three states: IDLE, ROUND and ADD.
REQ-015 SHALL, when in IDLE with cmp_start=1 and h_clr=0, load working registers a..h from H0..H7, set rnd_idx to 0, and move to ROUND.
REQ-016 SHALL, in every ROUND cycle, execute one FIPS 180-4 round using w and kt, assert kw_nxt=1 combinationally, and increment rnd_idx.
REQ-017 SHALL, when rnd_idx is 63 (SHA-256) or 79 (SHA-384) in ROUND, perform the final round and then move to ADD.
REQ-018 SHALL, in ADD, update Hi <= Hi + each working register (a..h respectively) modulo the word size, assert kw_done=1 and cmp_done=1 for that cycle, and return to IDLE.
REQ-019 SHALL have the following latency: with cmp_start at cycle T, rounds occupy cycles T+1..T+64 (or T+80 for SHA-384), ADD occurs at T+65 (or T+81), and the new hash_f is visible at T+66 (or T+82).
REQ-020 SHALL drive cmp_busy=1 in ROUND and in ADD, and 0 in IDLE.
REQ-021 SHALL ignore cmp_start when cmp_busy=1.
REQ-022 SHALL hold kw_nxt=0 and kw_done=0 outside ROUND and ADD respectively.
REQ-023 SHALL, in SHA-256 mode, keep working and hash values in bits [31:0] of 64-bit registers with the upper bits held at 0, and perform all additions modulo 2^32.
REQ-024 SHALL use the SHA-256 functions: Sigma0 = rotr 2^13^22, Sigma1 = rotr 6^11^25.
REQ-025 SHALL use the SHA-384 functions with all additions modulo 2^64: Sigma0 = rotr 28^34^39, Sigma1 = rotr 14^18^41.
REQ-026 SHALL use Ch(e,f,g) = (e&f)^(~e&g) and Maj(a,b,c) = (a&b)^(a&c)^(b&c) in both modes.
REQ-027 SHALL compute T1 = h+Sigma1(e)+Ch+K+W and T2 = Sigma0(a)+Maj, then update h=g, g=f, f=e, e=d+T1, d=c, c=b, b=a, a=T1+T2.
REQ-028 SHALL form hash_f in SHA-256 mode as {H0[31:0],...,H7[31:0],256'd0}.
REQ-029 SHALL form hash_f in SHA-384 mode as {H0,...,H5,128'd0}.
REQ-030 SHALL make hash_f a direct function of the H registers and never of the working registers.
REQ-031 SHALL, on h_clr in any state, load H0..H7 with the FIPS 180-4 IVs for h_flg_384 the next cycle, return to IDLE, set rnd_idx=0, and suppress kw_nxt, kw_done and cmp_done.
REQ-032 SHALL give h_clr priority over cmp_start when both arrive in the same cycle.
REQ-033 SHALL allow cmp_start in the cycle immediately after ADD, so back-to-back blocks chain with no extra idle cycle.
REQ-034 SHALL size rnd_idx so that it never wraps; it holds its value in IDLE after completion until the next cmp_start or h_clr.

Reset
REQ-035 SHALL, while rst_n=0, asynchronously force: state IDLE, H0..H7=0, a..h=0, rnd_idx=0, kw_nxt=0, kw_done=0, cmp_busy=0, cmp_done=0, hash_f=0.
REQ-036 SHALL require an h_clr before the first block after reset; a rst_n assertion mid-operation discards the block in progress.

Verification
REQ-037 SHALL be verified with: h_clr (SHA-256), padded "abc" block, cmp_start -> at T+66 hash_f[511:256] = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, cmp_done pulses once at T+65.
REQ-038 SHALL be verified with: h_clr (SHA-384), padded "abc" block -> at T+82 hash_f[511:128] = cb00753f45a35e8bb5a03d699ac65007272c32ab0eded1631a8b605a43ff5bed8086072ba1e7cc2358baeca134c825a7, kw_nxt high for exactly 80 cycles.
REQ-039 SHALL be verified with: SHA-256 two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", second cmp_start on the cycle after the first cmp_done -> hash_f[511:256] = 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
REQ-040 SHALL be verified with: cmp_start pulsed at round 10 -> ignored; rnd_idx continues without disturbance and the digest still matches the REQ-037 value.
REQ-041 SHALL be verified with: h_clr asserted at round 30 -> next cycle cmp_busy=0, H0 = 6a09e667 (SHA-256 IV), and no cmp_done or kw_done is issued.
REQ-042 SHALL be verified with: rst_n driven low at round 40 -> all outputs are 0 immediately, and the REQ-037 sequence rerun after h_clr yields the correct digest.
